trap_ctrl: RTL

- Trap sequencer between the pipeline and the machine-mode CSR file.
- Arbitrates simultaneous synchronous exceptions, pending interrupts and MRET into a single one-cycle trigger toward the CSR file (exception_trigger / interrupt_trigger / mret_trigger with pc, code, tval).
- Then issues a flush and a redirect PC to fetch, holding the pipeline stalled until fetch accepts the redirect.

---
 rtl/trap_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/trap_ctrl.sv
// Trap sequencer: arbitrates exceptions, interrupts and MRET into a single CSR trigger,
// then flushes the pipeline and holds it stalled until fetch takes the redirect.
module trap_ctrl #(
  parameter bit          VECTORED_EN     = 1'b1,
  parameter logic [31:0] RESET_PC_UNUSED = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [5:0]  exc_flags,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        mret_valid,
  input  logic [31:0] next_pc,
  input  logic        pipe_idle,
  input  logic        interrupt_pending,
  input  logic [31:0] mip,
  input  logic [31:0] mie,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        exception_trigger,
  output logic [31:0] exception_pc,
  output logic [31:0] exception_code,
  output logic [31:0] exception_tval,
  output logic        interrupt_trigger,
  output logic [31:0] interrupt_pc,
  output logic [31:0] interrupt_code,
  output logic        mret_trigger,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;
  typedef enum logic [1:0] {KIND_EXC, KIND_IRQ, KIND_MRET} kind_t;

  state_t      state, state_nxt;
  kind_t       kind, kind_nxt;
  logic [31:0] lat_pc, lat_pc_nxt;
  logic [31:0] lat_tval, lat_tval_nxt;
  logic [31:0] lat_code, lat_code_nxt;
  logic [31:0] target, target_nxt;
  logic [4:0]  exc_cause;
  logic [4:0]  irq_cause;
  logic        irq_found;
  logic [31:0] tvec_base;
  logic        commit_live;
  logic        unused_bits;

  assign unused_bits = ^{mip, mie};
  assign tvec_base   = {mtvec[31:2], 2'b00};

  always_comb begin
    exc_cause = 5'd0;
    if (exc_flags[0])      exc_cause = 5'd0;
    else if (exc_flags[1]) exc_cause = 5'd2;
    else if (exc_flags[2]) exc_cause = 5'd11;
    else if (exc_flags[3]) exc_cause = 5'd3;
    else if (exc_flags[4]) exc_cause = 5'd4;
    else if (exc_flags[5]) exc_cause = 5'd6;
  end

  // Machine external beats software beats timer.
  always_comb begin
    irq_found = 1'b1;
    irq_cause = 5'd0;
    if (mip[11] && mie[11])    irq_cause = 5'd11;
    else if (mip[3] && mie[3]) irq_cause = 5'd3;
    else if (mip[7] && mie[7]) irq_cause = 5'd7;
    else                       irq_found = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      kind     <= KIND_EXC;
      lat_pc   <= RESET_PC_UNUSED;
      lat_tval <= RESET_PC_UNUSED;
      lat_code <= 32'd0;
      target   <= RESET_PC_UNUSED;
    end else begin
      state    <= state_nxt;
      kind     <= kind_nxt;
      lat_pc   <= lat_pc_nxt;
      lat_tval <= lat_tval_nxt;
      lat_code <= lat_code_nxt;
      target   <= target_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    kind_nxt     = kind;
    lat_pc_nxt   = lat_pc;
    lat_tval_nxt = lat_tval;
    lat_code_nxt = lat_code;
    target_nxt   = target;
    case (state)
      IDLE: begin
        if (exc_valid && (|exc_flags)) begin
          kind_nxt     = KIND_EXC;
          lat_pc_nxt   = exc_pc;
          lat_tval_nxt = exc_tval;
          lat_code_nxt = {27'd0, exc_cause};
          state_nxt    = COMMIT;
        end else if (mret_valid) begin
          kind_nxt  = KIND_MRET;
          state_nxt = COMMIT;
        end else if (interrupt_pending) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!interrupt_pending) begin
          state_nxt = IDLE;
        end else if (pipe_idle) begin
          // A pending flag with nothing enabled is dropped and re-arbitrated from IDLE.
          if (irq_found) begin
            kind_nxt     = KIND_IRQ;
            lat_pc_nxt   = next_pc;
            lat_code_nxt = {1'b1, 26'd0, irq_cause};
            state_nxt    = COMMIT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      COMMIT: begin
        state_nxt = REDIRECT;
        case (kind)
          KIND_MRET: target_nxt = mepc;
          KIND_IRQ: begin
            if (VECTORED_EN && (mtvec[1:0] == 2'b01))
              target_nxt = tvec_base + {25'd0, lat_code[4:0], 2'b00};
            else
              target_nxt = tvec_base;
          end
          default: target_nxt = tvec_base;
        endcase
      end
      REDIRECT: begin
        if (redirect_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset in the commit cycle suppresses the trigger rather than letting it leak out.
  assign commit_live       = (state == COMMIT) && !rst;
  assign exception_trigger = commit_live && (kind == KIND_EXC);
  assign interrupt_trigger = commit_live && (kind == KIND_IRQ);
  assign mret_trigger      = commit_live && (kind == KIND_MRET);
  assign flush             = commit_live;
  assign stall             = (state != IDLE);
  assign redirect_valid    = (state == REDIRECT);
  assign redirect_pc       = redirect_valid ? target : RESET_PC_UNUSED;

  assign exception_pc   = exception_trigger ? lat_pc   : RESET_PC_UNUSED;
  assign exception_tval = exception_trigger ? lat_tval : RESET_PC_UNUSED;
  assign exception_code = exception_trigger ? lat_code : 32'd0;
  assign interrupt_pc   = interrupt_trigger ? lat_pc   : RESET_PC_UNUSED;
  assign interrupt_code = interrupt_trigger ? lat_code : 32'd0;

endmodule
